// File: rtl/signal_measurement_pkg.sv
// Shared types and width-derived constants for the per-channel signal characteriser.
package signal_measurement_pkg;

    localparam int DATA_BITS_DEFAULT = 12;

    typedef enum logic {
        SCHMITT_LOW  = 1'b0,
        SCHMITT_HIGH = 1'b1
    } schmitt_state_t;

    function automatic int sample_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sample_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

    function automatic int period_saturate(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/signal_measurement_if.sv
// Sample stream in, per-window measurement results out.
interface signal_measurement_if #(
    parameter int DATA_BITS = 12
);
    logic                        sampleValid;
    logic signed [DATA_BITS-1:0] sample;
    logic signed [DATA_BITS-1:0] signalMin;
    logic signed [DATA_BITS-1:0] signalMax;
    logic        [DATA_BITS-1:0] signalPeriod;
    logic                        measurementValid;

    modport master (
        output sampleValid, sample,
        input  signalMin, signalMax, signalPeriod, measurementValid
    );

    modport slave (
        input  sampleValid, sample,
        output signalMin, signalMax, signalPeriod, measurementValid
    );
endinterface

// File: rtl/signal_measurement_schmitt_crossing_detector.sv
// Hysteresis comparator around a moving midpoint; strobes on each qualified rising crossing.
module schmitt_crossing_detector
    import signal_measurement_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int HYSTERESIS = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        valid,
    input  logic signed [DATA_BITS-1:0] sample,
    input  logic signed [DATA_BITS-1:0] midpoint,
    output logic                        rising
);

    localparam logic signed [DATA_BITS:0] HYST = (DATA_BITS + 1)'(HYSTERESIS);

    schmitt_state_t state_q, state_d;

    logic signed [DATA_BITS:0] sample_ext;
    logic signed [DATA_BITS:0] thresh_hi;
    logic signed [DATA_BITS:0] thresh_lo;

    // One extra bit keeps midpoint +/- hysteresis from wrapping at the rails.
    always_comb begin
        sample_ext = {sample[DATA_BITS-1], sample};
        thresh_hi  = {midpoint[DATA_BITS-1], midpoint} + HYST;
        thresh_lo  = {midpoint[DATA_BITS-1], midpoint} - HYST;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SCHMITT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (valid) begin
            case (state_q)
                SCHMITT_LOW:  if (sample_ext >= thresh_hi) state_d = SCHMITT_HIGH;
                SCHMITT_HIGH: if (sample_ext <= thresh_lo) state_d = SCHMITT_LOW;
                default:      state_d = SCHMITT_LOW;
            endcase
        end
    end

    always_comb begin
        rising = valid && (state_q == SCHMITT_LOW) && (sample_ext >= thresh_hi);
    end

endmodule

// File: rtl/signal_measurement.sv
// Per-channel ADC characteriser: windowed min/max plus crossing-to-crossing period,
// published once per window of valid samples.
module signal_measurement
    import signal_measurement_pkg::*;
#(
    parameter int DATA_BITS      = DATA_BITS_DEFAULT,
    parameter int WINDOW_SAMPLES = 4096,
    parameter int WINDOW_BITS    = 13,
    parameter int HYSTERESIS     = 16
) (
    input logic                 clock,
    input logic                 reset,
    signal_measurement_if.slave sig
);

    localparam logic signed [DATA_BITS-1:0] RUN_MIN_INIT = DATA_BITS'(sample_max(DATA_BITS));
    localparam logic signed [DATA_BITS-1:0] RUN_MAX_INIT = DATA_BITS'(sample_min(DATA_BITS));
    localparam logic        [DATA_BITS-1:0] PERIOD_SAT   = DATA_BITS'(period_saturate(DATA_BITS));
    localparam logic      [WINDOW_BITS-1:0] WINDOW_LAST  = WINDOW_BITS'(WINDOW_SAMPLES - 1);

    logic [WINDOW_BITS-1:0]      window_count_q, window_count_d;
    logic signed [DATA_BITS-1:0] run_min_q, run_min_d;
    logic signed [DATA_BITS-1:0] run_max_q, run_max_d;
    logic [DATA_BITS-1:0]        period_count_q, period_count_d;
    logic [DATA_BITS-1:0]        last_period_q, last_period_d;
    logic signed [DATA_BITS-1:0] midpoint_q, midpoint_d;
    logic                        have_edge_q, have_edge_d;
    logic                        period_seen_q, period_seen_d;
    logic signed [DATA_BITS-1:0] signal_min_q, signal_min_d;
    logic signed [DATA_BITS-1:0] signal_max_q, signal_max_d;
    logic [DATA_BITS-1:0]        signal_period_q, signal_period_d;
    logic                        measurement_valid_q, measurement_valid_d;

    logic                        rising;
    logic signed [DATA_BITS-1:0] new_min;
    logic signed [DATA_BITS-1:0] new_max;
    logic [DATA_BITS-1:0]        period_inc;
    logic signed [DATA_BITS:0]   mid_sum;
    logic                        window_end;

    schmitt_crossing_detector #(
        .DATA_BITS  (DATA_BITS),
        .HYSTERESIS (HYSTERESIS)
    ) u_schmitt (
        .clock    (clock),
        .reset    (reset),
        .valid    (sig.sampleValid),
        .sample   (sig.sample),
        .midpoint (midpoint_q),
        .rising   (rising)
    );

    always_comb begin
        new_min    = (sig.sample < run_min_q) ? sig.sample : run_min_q;
        new_max    = (sig.sample > run_max_q) ? sig.sample : run_max_q;
        period_inc = (period_count_q == PERIOD_SAT) ? PERIOD_SAT : period_count_q + 1'b1;
        mid_sum    = {new_max[DATA_BITS-1], new_max} + {new_min[DATA_BITS-1], new_min};
        window_end = sig.sampleValid && (window_count_q == WINDOW_LAST);
    end

    // Crossing tracking deliberately ignores window boundaries; only the window bookkeeping restarts.
    always_comb begin
        window_count_d      = window_count_q;
        run_min_d           = run_min_q;
        run_max_d           = run_max_q;
        period_count_d      = period_count_q;
        last_period_d       = last_period_q;
        midpoint_d          = midpoint_q;
        have_edge_d         = have_edge_q;
        period_seen_d       = period_seen_q;
        signal_min_d        = signal_min_q;
        signal_max_d        = signal_max_q;
        signal_period_d     = signal_period_q;
        measurement_valid_d = 1'b0;

        if (sig.sampleValid) begin
            run_min_d      = new_min;
            run_max_d      = new_max;
            window_count_d = window_count_q + 1'b1;
            period_count_d = period_inc;

            if (rising) begin
                period_count_d = '0;
                have_edge_d    = 1'b1;
                if (have_edge_q) begin
                    last_period_d = period_inc;
                    period_seen_d = 1'b1;
                end
            end

            if (window_end) begin
                signal_min_d        = new_min;
                signal_max_d        = new_max;
                signal_period_d     = period_seen_d ? last_period_d : '0;
                midpoint_d          = DATA_BITS'(mid_sum >>> 1);
                run_min_d           = RUN_MIN_INIT;
                run_max_d           = RUN_MAX_INIT;
                period_seen_d       = 1'b0;
                window_count_d      = '0;
                measurement_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window_count_q      <= '0;
            run_min_q           <= RUN_MIN_INIT;
            run_max_q           <= RUN_MAX_INIT;
            period_count_q      <= '0;
            last_period_q       <= '0;
            midpoint_q          <= '0;
            have_edge_q         <= 1'b0;
            period_seen_q       <= 1'b0;
            signal_min_q        <= '0;
            signal_max_q        <= '0;
            signal_period_q     <= '0;
            measurement_valid_q <= 1'b0;
        end else begin
            window_count_q      <= window_count_d;
            run_min_q           <= run_min_d;
            run_max_q           <= run_max_d;
            period_count_q      <= period_count_d;
            last_period_q       <= last_period_d;
            midpoint_q          <= midpoint_d;
            have_edge_q         <= have_edge_d;
            period_seen_q       <= period_seen_d;
            signal_min_q        <= signal_min_d;
            signal_max_q        <= signal_max_d;
            signal_period_q     <= signal_period_d;
            measurement_valid_q <= measurement_valid_d;
        end
    end

    assign sig.signalMin        = signal_min_q;
    assign sig.signalMax        = signal_max_q;
    assign sig.signalPeriod     = signal_period_q;
    assign sig.measurementValid = measurement_valid_q;

endmodule
